// File: rtl/arm7tdmi_branch_ctrl.sv
// Branch sequencer between decode and fetch/register file. It handles B/BL/BX redirect,
// the LR and T-bit writes, and waits for the refill fetches before it accepts the next branch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a branch; a not-taken branch completes from here
// REDIRECT | strobes (flush/pc_load/lr_we/thumb_we) asserted this cycle
// REFILL   | counting refill fetches from the new stream
// DONE     | br_done/br_taken pulse for a taken branch
module arm7tdmi_branch_ctrl #(
    parameter int REFILL_CNT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic        is_bx,
    input  logic        branch_link,
    input  logic [23:0] branch_offset,
    input  logic [31:0] pc_in,
    input  logic        cond_met,
    input  logic [31:0] rm_value,
    input  logic        fetch_valid,
    input  logic        exc_abort,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        lr_we,
    output logic [31:0] lr_data,
    output logic        thumb_we,
    output logic        thumb_next,
    output logic        br_done,
    output logic        br_taken
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_REFILL   = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_flush;
    logic        r_pc_load;
    logic [31:0] r_pc_target;
    logic        r_lr_we;
    logic [31:0] r_lr_data;
    logic        r_thumb_we;
    logic        r_thumb_next;
    logic        r_br_done;
    logic        r_br_taken;

    logic        w_accept;
    logic [31:0] w_off_ext;
    logic [31:0] w_b_target;
    logic [31:0] w_bx_target;

    assign br_ready    = (r_state == S_IDLE) & ~exc_abort;
    assign w_accept    = br_valid & br_ready;
    assign w_off_ext   = {{6{branch_offset[23]}}, branch_offset, 2'b00};
    assign w_b_target  = pc_in + 32'd8 + w_off_ext;
    // Thumb targets are halfword aligned, ARM targets word aligned.
    assign w_bx_target = rm_value & (rm_value[0] ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_flush      <= 1'b0;
            r_pc_load    <= 1'b0;
            r_pc_target  <= 32'h0;
            r_lr_we      <= 1'b0;
            r_lr_data    <= 32'h0;
            r_thumb_we   <= 1'b0;
            r_thumb_next <= 1'b0;
            r_br_done    <= 1'b0;
            r_br_taken   <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_pc_load  <= 1'b0;
            r_lr_we    <= 1'b0;
            r_thumb_we <= 1'b0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (cond_met) begin
                            r_state   <= S_REDIRECT;
                            r_flush   <= 1'b1;
                            r_pc_load <= 1'b1;
                            if (is_bx) begin
                                r_pc_target  <= w_bx_target;
                                r_thumb_we   <= 1'b1;
                                r_thumb_next <= rm_value[0];
                            end else begin
                                r_pc_target <= w_b_target;
                                if (branch_link) begin
                                    r_lr_we   <= 1'b1;
                                    r_lr_data <= pc_in + 32'd4;
                                end
                            end
                        end else begin
                            r_br_done <= 1'b1;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (exc_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= 2'(REFILL_CNT);
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (exc_abort) begin
                        r_state <= S_IDLE;
                    end else if (fetch_valid) begin
                        if (r_cnt == 2'd1) begin
                            r_state    <= S_DONE;
                            r_br_done  <= 1'b1;
                            r_br_taken <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign flush      = r_flush;
    assign pc_load    = r_pc_load;
    assign pc_target  = r_pc_target;
    assign lr_we      = r_lr_we;
    assign lr_data    = r_lr_data;
    assign thumb_we   = r_thumb_we;
    assign thumb_next = r_thumb_next;
    assign br_done    = r_br_done;
    assign br_taken   = r_br_taken;

endmodule

// File: tb/tb_arm7tdmi_branch_ctrl.sv
// Directed bench for arm7tdmi_branch_ctrl (REFILL_CNT=2) with hand-computed expectations
// checked by immediate assertions.
module tb_arm7tdmi_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic        is_bx;
    logic        branch_link;
    logic [23:0] branch_offset;
    logic [31:0] pc_in;
    logic        cond_met;
    logic [31:0] rm_value;
    logic        fetch_valid;
    logic        exc_abort;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        thumb_we;
    logic        thumb_next;
    logic        br_done;
    logic        br_taken;

    int n_checks = 0;
    int n_fail   = 0;

    arm7tdmi_branch_ctrl #(.REFILL_CNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .is_bx(is_bx), .branch_link(branch_link), .branch_offset(branch_offset),
        .pc_in(pc_in), .cond_met(cond_met), .rm_value(rm_value),
        .fetch_valid(fetch_valid), .exc_abort(exc_abort), .flush(flush),
        .pc_load(pc_load), .pc_target(pc_target), .lr_we(lr_we), .lr_data(lr_data),
        .thumb_we(thumb_we), .thumb_next(thumb_next), .br_done(br_done),
        .br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic link, input logic [23:0] off, input logic [31:0] pc,
                           input logic cond);
        br_valid = 1'b1; is_bx = 1'b0; branch_link = link;
        branch_offset = off; pc_in = pc; cond_met = cond;
    endtask

    task automatic drive_bx(input logic [31:0] rm);
        br_valid = 1'b1; is_bx = 1'b1; branch_link = 1'b0; rm_value = rm; cond_met = 1'b1;
    endtask

    // Called in the REDIRECT cycle: supplies back-to-back fetches until br_done (bounded).
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        fetch_valid = 1'b1;
        while (br_done !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        fetch_valid = 1'b0;
        chk({tag, "_done"}, 32'(br_done), 32'd1);
        chk({tag, "_taken"}, 32'(br_taken), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd3);
        step;
    endtask

    initial begin
        logic [7:0] fv_pat;
        rst_n = 1'b0; br_valid = 1'b0; is_bx = 1'b0; branch_link = 1'b0;
        branch_offset = 24'h0; pc_in = 32'h0; cond_met = 1'b0; rm_value = 32'h0;
        fetch_valid = 1'b0; exc_abort = 1'b0;
        #12;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_target", pc_target, 32'h0);
        chk("rst_lr_data", lr_data, 32'h0);
        chk("rst_br_done", 32'(br_done), 32'd0);
        rst_n = 1'b1;
        step;

        // B 0xEA000001 at 0x1000; fetch during REDIRECT must be ignored
        drive_b(1'b0, 24'h000001, 32'h1000, 1'b1);
        step;
        br_valid = 1'b0;
        fetch_valid = 1'b1;
        chk("b_flush", 32'(flush), 32'd1);
        chk("b_pc_load", 32'(pc_load), 32'd1);
        chk("b_target", pc_target, 32'h100C);
        chk("b_lr_we", 32'(lr_we), 32'd0);
        chk("b_thumb_we", 32'(thumb_we), 32'd0);
        chk("b_ready_redir", 32'(br_ready), 32'd0);
        step;
        chk("b_t2_flush", 32'(flush), 32'd0);
        chk("b_t2_done", 32'(br_done), 32'd0);
        step;
        chk("b_t3_done", 32'(br_done), 32'd0);
        step;
        fetch_valid = 1'b0;
        chk("b_t4_done", 32'(br_done), 32'd1);
        chk("b_t4_taken", 32'(br_taken), 32'd1);
        chk("b_t4_ready", 32'(br_ready), 32'd0);
        step;
        chk("b_t5_ready", 32'(br_ready), 32'd1);
        chk("b_t5_done", 32'(br_done), 32'd0);

        // BL 0xEB000018 at 0x2000
        drive_b(1'b1, 24'h000018, 32'h2000, 1'b1);
        step;
        br_valid = 1'b0;
        chk("bl_pc_load", 32'(pc_load), 32'd1);
        chk("bl_target", pc_target, 32'h2068);
        chk("bl_lr_we", 32'(lr_we), 32'd1);
        chk("bl_lr_data", lr_data, 32'h2004);
        wait_done("bl");

        // BEQ not taken, followed immediately by BX 0x2001
        drive_b(1'b0, 24'h000003, 32'h3000, 1'b0);
        step;
        chk("nt_done", 32'(br_done), 32'd1);
        chk("nt_taken", 32'(br_taken), 32'd0);
        chk("nt_flush", 32'(flush), 32'd0);
        chk("nt_pc_load", 32'(pc_load), 32'd0);
        chk("nt_ready", 32'(br_ready), 32'd1);
        drive_bx(32'h2001);
        step;
        br_valid = 1'b0;
        chk("bx1_pc_load", 32'(pc_load), 32'd1);
        chk("bx1_target", pc_target, 32'h2000);
        chk("bx1_thumb_we", 32'(thumb_we), 32'd1);
        chk("bx1_thumb_next", 32'(thumb_next), 32'd1);
        chk("bx1_lr_we", 32'(lr_we), 32'd0);
        chk("bx1_lr_hold", lr_data, 32'h2004);
        chk("bx1_done", 32'(br_done), 32'd0);
        wait_done("bx1");

        drive_bx(32'h2002);
        step;
        br_valid = 1'b0;
        chk("bx2_target", pc_target, 32'h2000);
        chk("bx2_thumb_we", 32'(thumb_we), 32'd1);
        chk("bx2_thumb_next", 32'(thumb_next), 32'd0);
        wait_done("bx2");
        chk("bx2_thumb_hold", 32'(thumb_next), 32'd0);

        // Address wrap-around
        drive_b(1'b0, 24'h800000, 32'h0200_0000, 1'b1);
        step;
        br_valid = 1'b0;
        chk("wrap_neg_target", pc_target, 32'h0000_0008);
        wait_done("wrap_neg");
        drive_b(1'b0, 24'h7FFFFF, 32'hFFFF_FFF0, 1'b1);
        step;
        br_valid = 1'b0;
        chk("wrap_pos_target", pc_target, 32'h01FF_FFF4);
        wait_done("wrap_pos");
        chk("hold_target", pc_target, 32'h01FF_FFF4);

        // Refill with 3-cycle fetch gaps
        drive_b(1'b0, 24'h000001, 32'h4000, 1'b1);
        step;
        br_valid = 1'b1;
        fv_pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step;
            fetch_valid = fv_pat[i];
            chk("stall_ready", 32'(br_ready), 32'd0);
            chk("stall_done", 32'(br_done), 32'd0);
        end
        step;
        fetch_valid = 1'b0;
        br_valid = 1'b0;
        chk("stall_done_end", 32'(br_done), 32'd1);
        chk("stall_taken_end", 32'(br_taken), 32'd1);
        chk("stall_pc_load", 32'(pc_load), 32'd0);
        step;

        // Abort in REFILL with the final fetch present
        drive_b(1'b0, 24'h000002, 32'h5000, 1'b1);
        step;
        br_valid = 1'b0;
        fetch_valid = 1'b1;
        step;
        step;
        exc_abort = 1'b1;
        #1;
        chk("abort_ready_low", 32'(br_ready), 32'd0);
        step;
        exc_abort = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("abort_refill_ready", 32'(br_ready), 32'd1);
        chk("abort_refill_done", 32'(br_done), 32'd0);
        step;
        chk("abort_refill_done2", 32'(br_done), 32'd0);

        // Abort in IDLE blocks accept
        exc_abort = 1'b1;
        drive_b(1'b0, 24'h000001, 32'h6000, 1'b1);
        #1;
        chk("abort_idle_ready", 32'(br_ready), 32'd0);
        step;
        chk("abort_idle_pc_load", 32'(pc_load), 32'd0);
        exc_abort = 1'b0;
        step;
        br_valid = 1'b0;
        chk("after_abort_accept", 32'(pc_load), 32'd1);
        chk("after_abort_target", pc_target, 32'h600C);

        // Abort in REDIRECT: strobes stay for this cycle, IDLE next
        exc_abort = 1'b1;
        #1;
        chk("abort_redir_pc_load", 32'(pc_load), 32'd1);
        step;
        exc_abort = 1'b0;
        #1;
        chk("abort_redir_ready", 32'(br_ready), 32'd1);
        chk("abort_redir_strobe", 32'(pc_load), 32'd0);

        // Async reset mid-REFILL
        drive_b(1'b1, 24'h000010, 32'h7000, 1'b1);
        step;
        br_valid = 1'b0;
        chk("pre_rst_lr", lr_data, 32'h7004);
        step;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(br_ready), 32'd1);
        chk("mid_rst_target", pc_target, 32'h0);
        chk("mid_rst_lr", lr_data, 32'h0);
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_done", 32'(br_done), 32'd0);
        #2;
        rst_n = 1'b1;
        step;
        chk("post_rst_done", 32'(br_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arm7tdmi_branch_ctrl.md
# arm7tdmi_branch_ctrl

Branch sequencer between `arm7tdmi_decode` and the fetch/register-file stages. It accepts one decoded B/BL/BX per handshake and evaluates the supplied condition result. On a taken branch it computes the target, redirects fetch and flushes the pipeline. It also writes R14 for BL, switches ARM/Thumb state for BX, and holds off further branches until two refill fetches have arrived (the ARM7TDMI 2S+1N branch cost).

## Interface
Parameters:
- `REFILL_CNT`, default 2: fetches required after redirect before the controller accepts the next branch (legal range 1-3).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `br_valid`  in  1  decoded branch presented (decode_valid & is_branch).
- `br_ready`  out  1  controller can accept a branch; high only in IDLE.
- `is_bx`  in  1  1 = BX, 0 = B/BL.
- `branch_link`  in  1  BL when is_bx=0; ignored for BX.
- `branch_offset`  in  24  signed word offset from decode.
- `pc_in`  in  32  address of the branch instruction.
- `cond_met`  in  1  condition-code result for this instruction.
- `rm_value`  in  32  Rm contents for BX.
- `fetch_valid`  in  1  one refill fetch completed this cycle.
- `exc_abort`  in  1  exception entry; cancels the sequence.
- `flush`  out  1  one-cycle pipeline flush pulse.
- `pc_load`  out  1  one-cycle fetch redirect strobe.
- `pc_target`  out  32  redirect address, valid with pc_load.
- `lr_we`  out  1  one-cycle R14 write strobe.
- `lr_data`  out  32  R14 write value.
- `thumb_we`  out  1  one-cycle CPSR.T write strobe.
- `thumb_next`  out  1  new T bit, valid with thumb_we.
- `br_done`  out  1  one-cycle completion pulse (taken or not taken).
- `br_taken`  out  1  qualifies br_done: 1 = branch was taken.

## Operation
- Accept occurs on the edge where `br_valid & br_ready`. Inputs are sampled only at accept.
- Target for B/BL:
  - `pc_in + 8 + {{6{off[23]}}, off, 2'b00}`.
  - 32-bit modulo arithmetic; wrap-around is silent.
- LR for BL: `pc_in + 4`.
- BX:
  - `thumb_next = rm_value[0]`.
  - `pc_target = rm_value & 32'hFFFF_FFFE` when rm_value[0]=1.
  - Otherwise `pc_target = rm_value & 32'hFFFF_FFFC`.
  - BX never writes LR.
- Not taken (`cond_met=0`) at accept:
  - Next cycle: `br_done=1`, `br_taken=0`.
  - No flush, pc_load, lr_we or thumb_we.
  - State stays IDLE, so a new branch may be accepted on the very next edge.
- State machine:
  - IDLE: accept with cond_met=1 -> REDIRECT.
  - REDIRECT (one cycle):
    - `flush=1`, `pc_load=1`, pc_target driven.
    - `lr_we=1` if BL; `thumb_we=1` if BX.
    - Refill counter loads REFILL_CNT. Next state REFILL.
  - REFILL:
    - Each cycle with `fetch_valid=1` decrements the counter.
    - When the counter is 1 and fetch_valid=1 -> DONE.
    - fetch_valid during REDIRECT is ignored (the fetch belongs to the flushed stream).
  - DONE (one cycle): `br_done=1`, `br_taken=1`, then -> IDLE.
- `exc_abort`:
  - In REDIRECT, REFILL or DONE, forces IDLE on the next edge.
  - No br_done pulse. Strobes already issued are not undone.
  - In REDIRECT, the abort edge still leaves that cycle's strobes asserted; exception logic has priority downstream.
  - `exc_abort` in IDLE blocks accept that cycle: br_ready is low whenever exc_abort=1.
- `br_valid` while not ready is held by the source and not consumed.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - State IDLE, `br_ready=1`.
  - flush, pc_load, lr_we, thumb_we, thumb_next, br_done and br_taken are 0.
  - pc_target and lr_data are 32'h0.
- All outputs except br_ready are registered. br_ready = (state==IDLE) & ~exc_abort.
- Accept at edge T:
  - Taken: redirect strobes high in cycle T+1.
  - Earliest br_done is T+1+REFILL_CNT+1, with fetch_valid on consecutive cycles from T+2. With REFILL_CNT=2, br_done is in cycle T+4.
  - Not taken: br_done in cycle T+1.
- Taken-branch throughput: one per REFILL_CNT+3 cycles minimum.
- pc_target, lr_data and thumb_next hold their last value after the strobe cycle.
- Reset asserted mid-sequence returns to IDLE immediately with all strobes low.

## Test plan
- B 0xEA000001, pc_in=0x1000, cond_met=1, fetch_valid from T+2 -> T+1: flush=pc_load=1, pc_target=0x100C, lr_we=0; T+4: br_done=1, br_taken=1.
- BL 0xEB000018, pc_in=0x2000 -> pc_target=0x2068, lr_we=1, lr_data=0x2004 in the same cycle as pc_load.
- BEQ 0x0A000003, cond_met=0 -> T+1: br_done=1, br_taken=0, no flush; a second branch is accepted at T+1.
- BX rm_value=0x2001 -> pc_target=0x2000, thumb_we=1, thumb_next=1. BX rm_value=0x2002 -> pc_target=0x2000, thumb_next=0.
- Edge wrap: offset 0x800000, pc_in=0x2000000 -> 0x8. Offset 0x7FFFFF, pc_in=0xFFFFFFF0 -> 0x01FFFFF4 (wraps).
- Stall and abort cases:
  - fetch_valid gaps of 3 cycles -> br_done delayed accordingly and br_ready low throughout.
  - exc_abort in REFILL -> IDLE next cycle, no br_done.
  - rst_n pulse mid-REFILL -> all outputs at reset values asynchronously.
